// File: rtl/frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ctrl_pkg
//  Description : Shared types and constants for the frame-synchronous
//                controller (FSM states, bounding-box record, helpers).
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_ctrl_pkg;

    localparam int FRAME_COORD_W = 13;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        RUN       = 2'd1,
        SAMPLE    = 2'd2,
        COMMIT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [FRAME_COORD_W-1:0] top;
        logic [FRAME_COORD_W-1:0] bot;
        logic [FRAME_COORD_W-1:0] left;
        logic [FRAME_COORD_W-1:0] right;
    } bbox_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Single-bit switch debouncer; the stable value follows the
//                raw input once it has differed for DEBOUNCE_CYCLES cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Any return to the stable level restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (i_raw != stable_q) begin
            if (cnt_q == C_CNT_LAST) begin
                stable_d = i_raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign o_stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sync_ctrl
//  Description : Commits debounced switch config at frame boundaries and
//                publishes a validated bounding box, centroid and frame stats.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sync_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int COORD_W         = FRAME_COORD_W,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LOST_FRAMES     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vs_ni,
    input  logic               filter_req,
    input  logic               rect_req,
    input  logic [3:0]         thresh_req,
    input  logic [COORD_W-1:0] top_i,
    input  logic [COORD_W-1:0] bot_i,
    input  logic [COORD_W-1:0] left_i,
    input  logic [COORD_W-1:0] right_i,
    output logic               filter_en,
    output logic               rect_en,
    output logic [3:0]         thresh,
    output logic               box_valid,
    output logic [COORD_W-1:0] box_top,
    output logic [COORD_W-1:0] box_bot,
    output logic [COORD_W-1:0] box_left,
    output logic [COORD_W-1:0] box_right,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               obj_present,
    output logic [15:0]        frame_cnt,
    output logic               frame_tick
);

    localparam int         NUM_REQ     = 6;
    localparam logic [3:0] C_LOST      = 4'(LOST_FRAMES);

    // ------------------------------------------------------------------
    // Switch debouncing: {thresh[3:0], rect, filter}
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_deb;

    assign w_req = {thresh_req, rect_req, filter_req};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_debounce
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_req[g]),
            .o_stable(w_deb[g])
        );
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               vs_q, vs_d;
    bbox_t              hold_q, hold_d;
    logic               filter_en_q, filter_en_d;
    logic               rect_en_q, rect_en_d;
    logic [3:0]         thresh_q, thresh_d;
    logic               box_valid_q, box_valid_d;
    logic [COORD_W-1:0] box_top_q, box_top_d;
    logic [COORD_W-1:0] box_bot_q, box_bot_d;
    logic [COORD_W-1:0] box_left_q, box_left_d;
    logic [COORD_W-1:0] box_right_q, box_right_d;
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic [3:0]         miss_q, miss_d;
    logic               obj_present_q, obj_present_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_tick_q, frame_tick_d;

    logic               w_fall;
    logic               w_box_ok;
    logic [COORD_W:0]   w_sum_x;
    logic [COORD_W:0]   w_sum_y;

    assign w_fall = vs_q & ~vs_ni;

    assign w_box_ok = ~hold_q.top[COORD_W-1] & ~hold_q.bot[COORD_W-1]
                    & (hold_q.bot >= hold_q.top)
                    & (hold_q.right >= hold_q.left);

    // One extra bit keeps the midpoint exact for coordinates near full scale.
    assign w_sum_x = {1'b0, hold_q.left} + {1'b0, hold_q.right};
    assign w_sum_y = {1'b0, hold_q.top}  + {1'b0, hold_q.bot};

    always_comb begin
        state_d       = state_q;
        vs_d          = vs_ni;
        hold_d        = hold_q;
        filter_en_d   = filter_en_q;
        rect_en_d     = rect_en_q;
        thresh_d      = thresh_q;
        box_valid_d   = box_valid_q;
        box_top_d     = box_top_q;
        box_bot_d     = box_bot_q;
        box_left_d    = box_left_q;
        box_right_d   = box_right_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        miss_d        = miss_q;
        frame_cnt_d   = frame_cnt_q;
        frame_tick_d  = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                // The frame in flight at reset is partial, so only re-align.
                if (w_fall) state_d = RUN;
            end
            RUN: begin
                if (w_fall) state_d = SAMPLE;
            end
            SAMPLE: begin
                hold_d.top   = top_i;
                hold_d.bot   = bot_i;
                hold_d.left  = left_i;
                hold_d.right = right_i;
                state_d      = COMMIT;
            end
            COMMIT: begin
                filter_en_d  = w_deb[0];
                rect_en_d    = w_deb[1];
                thresh_d     = w_deb[5:2];
                box_valid_d  = w_box_ok;
                if (w_box_ok) begin
                    box_top_d   = hold_q.top;
                    box_bot_d   = hold_q.bot;
                    box_left_d  = hold_q.left;
                    box_right_d = hold_q.right;
                    cx_d        = COORD_W'(w_sum_x >> 1);
                    cy_d        = COORD_W'(w_sum_y >> 1);
                    miss_d      = 4'd0;
                end else begin
                    miss_d      = sat_inc4(miss_q);
                end
                frame_cnt_d  = frame_cnt_q + 16'd1;
                frame_tick_d = 1'b1;
                state_d      = RUN;
            end
            default: state_d = WAIT_SYNC;
        endcase

        obj_present_d = (miss_d < C_LOST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_SYNC;
            vs_q          <= 1'b1;
            hold_q        <= '0;
            filter_en_q   <= 1'b0;
            rect_en_q     <= 1'b0;
            thresh_q      <= 4'd0;
            box_valid_q   <= 1'b0;
            box_top_q     <= '0;
            box_bot_q     <= '0;
            box_left_q    <= '0;
            box_right_q   <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            miss_q        <= C_LOST;
            obj_present_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_d;
            hold_q        <= hold_d;
            filter_en_q   <= filter_en_d;
            rect_en_q     <= rect_en_d;
            thresh_q      <= thresh_d;
            box_valid_q   <= box_valid_d;
            box_top_q     <= box_top_d;
            box_bot_q     <= box_bot_d;
            box_left_q    <= box_left_d;
            box_right_q   <= box_right_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            miss_q        <= miss_d;
            obj_present_q <= obj_present_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign filter_en   = filter_en_q;
    assign rect_en     = rect_en_q;
    assign thresh      = thresh_q;
    assign box_valid   = box_valid_q;
    assign box_top     = box_top_q;
    assign box_bot     = box_bot_q;
    assign box_left    = box_left_q;
    assign box_right   = box_right_q;
    assign cx          = cx_q;
    assign cy          = cy_q;
    assign obj_present = obj_present_q;
    assign frame_cnt   = frame_cnt_q;
    assign frame_tick  = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sync_ctrl
//  Description : Directed self-checking bench for frame_sync_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sync_ctrl;

    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vs_ni = 1'b1;
    logic          filter_req = 1'b0;
    logic          rect_req = 1'b0;
    logic [3:0]    thresh_req = 4'd0;
    logic [CW-1:0] top_i = '0, bot_i = '0, left_i = '0, right_i = '0;
    logic          filter_en, rect_en, box_valid, obj_present, frame_tick;
    logic [3:0]    thresh;
    logic [CW-1:0] box_top, box_bot, box_left, box_right, cx, cy;
    logic [15:0]   frame_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    int            tick_count = 0;
    logic [15:0]   exp_cnt = 16'd0;

    frame_sync_ctrl #(
        .COORD_W        (CW),
        .DEBOUNCE_CYCLES(8),
        .LOST_FRAMES    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vs_ni      (vs_ni),
        .filter_req (filter_req),
        .rect_req   (rect_req),
        .thresh_req (thresh_req),
        .top_i      (top_i),
        .bot_i      (bot_i),
        .left_i     (left_i),
        .right_i    (right_i),
        .filter_en  (filter_en),
        .rect_en    (rect_en),
        .thresh     (thresh),
        .box_valid  (box_valid),
        .box_top    (box_top),
        .box_bot    (box_bot),
        .box_left   (box_left),
        .box_right  (box_right),
        .cx         (cx),
        .cy         (cy),
        .obj_present(obj_present),
        .frame_cnt  (frame_cnt),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_tick) tick_count <= tick_count + 1;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the end (got hang, expected finish)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_box(input logic [CW-1:0] t, b, l, r);
        top_i = t; bot_i = b; left_i = l; right_i = r;
    endtask

    // Fall on vs_ni; results are due three edges later, pulse lasts one cycle.
    task automatic run_frame(input string tag);
        repeat (2) @(negedge clk);
        vs_ni = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_tick_early"}, frame_tick, 1'b0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check({tag, "_tick"}, frame_tick, 1'b1);
        check({tag, "_cnt"}, frame_cnt, exp_cnt);
        @(negedge clk);
        check({tag, "_tick_width"}, frame_tick, 1'b0);
        vs_ni = 1'b1;
    endtask

    // First fall after reset only re-aligns: no tick expected.
    task automatic sync_fall(input string tag);
        int base;
        base = tick_count;
        @(negedge clk) vs_ni = 1'b0;
        repeat (6) @(negedge clk);
        vs_ni = 1'b1;
        repeat (2) @(negedge clk);
        check({tag, "_no_tick"}, tick_count - base, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_filter"}, filter_en, 1'b0);
        check({tag, "_rect"}, rect_en, 1'b0);
        check({tag, "_thresh"}, thresh, 4'd0);
        check({tag, "_valid"}, box_valid, 1'b0);
        check({tag, "_box"}, {box_top, box_bot, box_left, box_right} != '0, 1'b0);
        check({tag, "_cxcy"}, {cx, cy}, 0);
        check({tag, "_present"}, obj_present, 1'b0);
        check({tag, "_cnt"}, frame_cnt, 16'd0);
        check({tag, "_tick"}, frame_tick, 1'b0);
    endtask

    initial begin
        int base;
        set_box(13'h1000, 13'd200, 13'd300, 13'd401);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        sync_fall("sync0");

        // Glitch of 3 cycles must never reach the committed threshold.
        thresh_req = 4'd5;
        repeat (3) @(negedge clk);
        thresh_req = 4'd0;
        set_box(13'd100, 13'd200, 13'd300, 13'd401);
        run_frame("f1");
        check("f1_thresh_glitch", thresh, 4'd0);
        check("f1_valid", box_valid, 1'b1);
        check("f1_cx", cx, 13'd350);
        check("f1_cy", cy, 13'd150);
        check("f1_present", obj_present, 1'b1);
        check("f1_box", {box_top, box_bot, box_left, box_right},
              {13'd100, 13'd200, 13'd300, 13'd401});

        // Stable config only shows up at the next commit.
        thresh_req = 4'd5; filter_req = 1'b1; rect_req = 1'b1;
        repeat (12) @(negedge clk);
        check("deb_thresh_pre", thresh, 4'd0);
        check("deb_filter_pre", filter_en, 1'b0);
        run_frame("f2");
        check("f2_thresh", thresh, 4'd5);
        check("f2_filter", filter_en, 1'b1);
        check("f2_rect", rect_en, 1'b1);

        // Four lost frames: box held, presence drops on the 4th.
        set_box(13'h1000, 13'd200, 13'd300, 13'd401);
        for (int i = 1; i <= 4; i++) begin
            run_frame($sformatf("lost%0d", i));
            check($sformatf("lost%0d_valid", i), box_valid, 1'b0);
            check($sformatf("lost%0d_top", i), box_top, 13'd100);
            check($sformatf("lost%0d_cx", i), cx, 13'd350);
            check($sformatf("lost%0d_present", i), obj_present, (i < 4) ? 1'b1 : 1'b0);
        end

        set_box(13'd10, 13'd20, 13'd30, 13'd41);
        run_frame("f7");
        check("f7_valid", box_valid, 1'b1);
        check("f7_present", obj_present, 1'b1);
        check("f7_cxcy", {cx, cy}, {13'd35, 13'd15});

        set_box(13'd50, 13'd40, 13'd0, 13'd5);
        run_frame("inv");
        check("inv_valid", box_valid, 1'b0);
        check("inv_top_held", box_top, 13'd10);
        check("inv_cy_held", cy, 13'd15);

        set_box(13'd20, 13'd10, 13'd9, 13'd8);
        run_frame("inv2");
        check("inv2_valid", box_valid, 1'b0);

        // Extra fall lands while the controller is committing.
        set_box(13'd1, 13'd3, 13'd5, 13'd7);
        repeat (2) @(negedge clk);
        base = tick_count;
        vs_ni = 1'b0;
        @(negedge clk) vs_ni = 1'b1;
        @(negedge clk) vs_ni = 1'b0;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        check("spur_tick", frame_tick, 1'b1);
        check("spur_cxcy", {cx, cy}, {13'd6, 13'd2});
        repeat (6) @(negedge clk);
        vs_ni = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_one_tick", tick_count - base, 1);
        check("spur_cnt", frame_cnt, exp_cnt);

        // Full-scale coordinates and counter wrap.
        force dut.frame_cnt_q = 16'hFFFE;
        #1 release dut.frame_cnt_q;
        exp_cnt = 16'hFFFE;
        set_box(13'd4000, 13'd4095, 13'd8000, 13'd8191);
        run_frame("wrap_a");
        check("big_cx", cx, 13'd8095);
        check("big_cy", cy, 13'd4047);
        run_frame("wrap_b");
        check("wrap_zero", frame_cnt, 16'd0);

        // Mid-frame reset, then resynchronisation.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_all_zero("midrst");
        exp_cnt = 16'd0;
        sync_fall("resync");
        set_box(13'd100, 13'd200, 13'd300, 13'd401);
        run_frame("after_rst");
        check("after_rst_valid", box_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
